demux1to8_deser: RTL and testbench
==================================

Name: demux1to8_deser

Overview:
- Receive-side counterpart of the 8:1 mux tree: takes a serial bit stream, one bit per accepted beat, and steers each bit to one of 8 lane registers using an internal 3-bit lane counter (sel).
- Presents the completed 8-bit word with a valid/ready handshake.
- Sits at the far end of any link driven by the 8:1 mux, with the mux select stepping 0..7.

Parameters:
- LANES, 8, number of output lanes; fixed at 8 for this revision, and any other value is a configuration error.
- SEL_W, 3, lane counter width; localparam derived as $clog2(LANES), not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous abort of the partially filled word.
- in_valid  input  1  serial bit d is valid this cycle.
- in_ready  output  1  block accepts d this cycle.
- d  input  1  serial data bit.
- sel  output  3  lane index the next accepted bit is written to.
- out_valid  output  1  q holds a complete word.
- out_ready  input  1  consumer takes q this cycle.
- q  output  8  lane registers; q[k] holds the bit received for lane k.

Behaviour:
- Reset (rst=1 at the clock edge): state=FILL, sel=0, out_valid=0, q=8'h00. rst takes priority over every other input.
- Accept rule: a bit is accepted when in_valid && in_ready at the clock edge.
- FILL state:
  - in_ready=1.
  - On accept: q[sel] <= d, sel <= sel+1. All other lanes hold.
  - Accept while sel==7: sel wraps to 0, state -> HOLD, out_valid=1 from the next cycle.
  - Latency: out_valid rises 1 cycle after the 8th accepted bit.
- HOLD state:
  - out_valid=1, q stable, in_ready=out_ready.
  - out_valid && out_ready, no accept: out_valid -> 0, state -> FILL, sel=0.
  - out_valid && out_ready with accept (simultaneous event): q[0] <= d, sel -> 1, state -> FILL. Zero-bubble back-to-back words.
  - out_valid && !out_ready: stall. q, sel and state hold; d is not accepted.
- clr:
  - In FILL: sel <= 0; any accept in the same cycle is dropped; q lanes are not cleared.
  - In HOLD: clr is ignored. A completed word is never discarded.
- Lane content during FILL: unwritten lanes keep stale values from the previous word. q is meaningful only while out_valid=1.
- Reset mid-word or mid-HOLD: the partial or pending word is lost, returning to the reset values above.
- Throughput: 1 bit/cycle sustained, 8 cycles per word, no idle cycles when out_ready is held at 1.

Optional Feature:
- Macro DEMUX1TO8_MSB_FIRST_EN.
- Defined: the first accepted bit of a word is written to q[7], then q[6] down to q[0]. Write lane = 7-sel. The sel port still counts 0..7, and handshakes are unchanged.
- Undefined: LSB-first, write lane = sel, as specified above.

Decomposition:
- Package demux_pkg:
  - LANES=8 and SEL_W=3 constants.
  - State enum with FILL=1'b0 and HOLD=1'b1.
  - Function lane_of(sel) giving the write lane for the selected bit order.
- One natural sub-module, decoder3to8:
  - Combinational one-hot write-enable decode of the write lane, gated by the accept condition.
  - The structural mirror of the mux select tree.
  - The top holds the counter, FSM and lane registers.

Test Plan:
- Reset then 8 accepts of d=1,0,1,1,0,0,1,0 with out_ready=0 -> q=8'h4D, out_valid=1 on the cycle after the 8th bit, in_ready=0 while held; with DEMUX1TO8_MSB_FIRST_EN defined -> q=8'hB2.
- Word 8'hA5 delivered, then out_ready=1 with in_valid=1 and d=1 in the same cycle -> out_valid=0, sel=1, q[0]=1 next cycle, with no dropped bit across two continuous words.
- 3 bits accepted, then clr=1 with in_valid=1 -> sel=0, that bit is dropped; the next 8 bits of 8'h3C give q=8'h3C.
- clr=1 during HOLD with q=8'hF0 -> out_valid stays 1, q=8'hF0 until out_ready is asserted.
- rst=1 after 5 bits, or during HOLD with in_valid=1 -> next cycle sel=0, out_valid=0, q=8'h00, in_ready=1.
- in_valid toggled randomly, 64 words -> each word equals the reference model, sel wraps 7->0 exactly once per word, and q never changes while out_valid && !out_ready.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants, FSM state type and lane-order helper for the 1:8 deserializer.
// Pure declarations; no timing of its own.
// Build option DEMUX1TO8_MSB_FIRST_EN flips the lane fill order to MSB-first.
package demux_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = $clog2(LANES);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Map the bit-position counter onto the physical lane that receives the bit.
  function automatic logic [SEL_W-1:0] lane_of(input logic [SEL_W-1:0] sel);
`ifdef DEMUX1TO8_MSB_FIRST_EN
    return SEL_W'(LANES - 1) - sel;
`else
    return sel;
`endif
  endfunction

endpackage

// File: rtl/decoder3to8.sv
// One-hot write-enable decode of a 3-bit lane index, gated by an enable.
// Purely combinational, zero cycles.
// No handshake; the caller folds backpressure into en.
module decoder3to8 (
  input  logic [2:0] lane,
  input  logic       en,
  output logic [7:0] we
);

  // Raise exactly one enable when en is set, none otherwise.
  always_comb begin
    we = '0;
    if (en) begin
      we[lane] = 1'b1;
    end
  end

endmodule

// File: rtl/demux1to8_deser.sv
// Serial-to-parallel 1:8 deserializer: steers one bit per accepted beat into 8 lane registers.
// Word is presented (out_valid) one cycle after the 8th accepted bit; 1 bit/cycle sustained.
// While a word waits, in_ready follows out_ready, allowing zero-bubble back-to-back words.
// Build option DEMUX1TO8_MSB_FIRST_EN fills q[7] first instead of q[0].
module demux1to8_deser
  import demux_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             d,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       q
);

  // The lane decoder and the word width are hard-wired to eight lanes.
  if (LANES != 8) begin : g_bad_lanes
    $error("demux1to8_deser: LANES must be 8");
  end

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             accept;
  logic             wr_en;
  logic [7:0]       we;

  assign out_valid = (state == HOLD);
  assign in_ready  = (state == FILL) || out_ready;
  assign accept    = in_valid && in_ready;

  // clr drops a same-cycle bit only while filling; a held word ignores clr.
  // In HOLD sel is already 0, so the accepted bit lands in the first lane of the new word.
  assign wr_en = accept && !(clr && (state == FILL));

  decoder3to8 u_dec (
    .lane (lane_of(sel)),
    .en   (wr_en),
    .we   (we)
  );

  // State and lane counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
    end
  end

  // Next-state and lane-counter logic.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    unique case (state)
      FILL: begin
        if (clr) begin
          sel_nxt = '0;
        end else if (accept) begin
          sel_nxt = sel + SEL_W'(1);
          if (sel == SEL_W'(LANES - 1)) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = FILL;
          sel_nxt   = accept ? SEL_W'(1) : '0;
        end
      end
      default: begin
        state_nxt = FILL;
        sel_nxt   = '0;
      end
    endcase
  end

  // Lane registers: only the decoded lane takes d; all others hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= (q & ~we) | (we & {8{d}});
    end
  end

endmodule

// File: tb/tb_demux1to8_deser.sv
// Self-checking bench for demux1to8_deser: directed scenarios then randomized traffic.
// Reference model tracks the word as a bit count plus a position-addressed byte.
// Honours DEMUX1TO8_MSB_FIRST_EN for the expected lane order.
module tb_demux1to8_deser;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, in_ready, d, out_valid, out_ready;
  logic [2:0] sel;
  logic [7:0] q;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0] m_q;
  int         m_n;
  bit         m_pend;
  int         words = 0;
  int         wraps = 0;
  int         prev_sel = 0;

  demux1to8_deser dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // k-th bit of a word goes to this lane
  function automatic int pos(input int k);
`ifdef DEMUX1TO8_MSB_FIRST_EN
    return 7 - k;
`else
    return k;
`endif
  endfunction

  // Expected q for a word whose bits were sent w[0] first
  function automatic logic [7:0] exp_word(input logic [7:0] w);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[pos(k)] = w[k];
    return r;
  endfunction

  task automatic model(input logic r, input logic c, input logic v, input logic b, input logic o);
    if (r) begin
      m_q = '0; m_n = 0; m_pend = 0;
    end else if (m_pend) begin
      if (o) begin
        m_pend = 0;
        m_n    = 0;
        if (v) begin
          m_q[pos(0)] = b;
          m_n = 1;
        end
      end
    end else if (c) begin
      m_n = 0;
    end else if (v) begin
      m_q[pos(m_n)] = b;
      m_n++;
      if (m_n == 8) begin
        m_n = 0;
        m_pend = 1;
        words++;
      end
    end
  endtask

  // One clock cycle: drive, check in_ready, advance model, clock, check outputs.
  task automatic cyc(input logic r, input logic c, input logic v, input logic b, input logic o);
    rst = r; clr = c; in_valid = v; d = b; out_ready = o;
    #1;
    check("in_ready", {7'b0, in_ready}, {7'b0, (!m_pend || o)});
    model(r, c, v, b, o);
    @(posedge clk);
    #1;
    check("out_valid", {7'b0, out_valid}, {7'b0, m_pend});
    check("sel", {5'b0, sel}, 8'(m_n));
    check("q", q, m_q);
    if (prev_sel == 7 && sel == 3'd0) wraps++;
    prev_sel = int'(sel);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 1'b1, w[k], 1'b0);
  endtask

  initial begin
    logic [7:0] bits;
    logic [7:0] q_before;
    logic       rv, rb, ro, stall;
    int         w0, ncyc;

    // Reset
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; d = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_q = '0; m_n = 0; m_pend = 0;
    check("rst_sel", {5'b0, sel}, 8'h00);
    check("rst_out_valid", {7'b0, out_valid}, 8'h00);
    check("rst_q", q, 8'h00);
    check("rst_in_ready", {7'b0, in_ready}, 8'h01);

    // Word d=1,0,1,1,0,0,1,0 held with out_ready=0
    bits = 8'b0100_1101;
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 1'b1, bits[k], 1'b0);
`ifdef DEMUX1TO8_MSB_FIRST_EN
    check("word1_const", q, 8'hB2);
`else
    check("word1_const", q, 8'h4D);
`endif
    check("word1_valid", {7'b0, out_valid}, 8'h01);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);          // stall: bit refused
    check("stall_in_ready", {7'b0, in_ready}, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);          // drain

    // A5, then simultaneous handshake + accept of d=1, then rest of 5B
    send_word(8'hA5);
    check("a5_q", q, exp_word(8'hA5));
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("b2b_valid", {7'b0, out_valid}, 8'h00);
    check("b2b_sel", {5'b0, sel}, 8'h01);
    check("b2b_lane0", {7'b0, q[pos(0)]}, 8'h01);
    bits = 8'h5B;
    for (int k = 1; k < 8; k++) cyc(1'b0, 1'b0, 1'b1, bits[k], 1'b0);
    check("b2b_word", q, exp_word(8'h5B));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 3 bits, clr with in_valid, then 3C
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("clr_sel", {5'b0, sel}, 8'h00);
    send_word(8'h3C);
    check("clr_word", q, exp_word(8'h3C));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // clr during HOLD is ignored
    send_word(8'hF0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_clr_valid", {7'b0, out_valid}, 8'h01);
    check("hold_clr_q", q, exp_word(8'hF0));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("hold_clr_drain", {7'b0, out_valid}, 8'h00);

    // Reset mid-word
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mid_sel", {5'b0, sel}, 8'h00);
    check("rst_mid_q", q, 8'h00);
    check("rst_mid_in_ready", {7'b0, in_ready}, 8'h01);

    // Reset during HOLD with in_valid
    send_word(8'h96);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("rst_hold_valid", {7'b0, out_valid}, 8'h00);
    check("rst_hold_sel", {5'b0, sel}, 8'h00);
    check("rst_hold_q", q, 8'h00);
    check("rst_hold_in_ready", {7'b0, in_ready}, 8'h01);

    // Randomized traffic: 64 words
    w0 = words;
    wraps = 0;
    prev_sel = int'(sel);
    ncyc = 0;
    while ((words - w0) < 64 && ncyc < 4000) begin
      rv = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      ro = ($urandom_range(0, 3) != 0);
      stall = out_valid && !ro;
      q_before = q;
      cyc(1'b0, 1'b0, rv, rb, ro);
      if (stall) check("stall_q_hold", q, q_before);
      ncyc++;
    end
    check("rand_words", 8'(words - w0), 8'd64);
    check("rand_wraps", 8'(wraps), 8'(words - w0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
